clk_div_multi: RTL and testbench
================================

Name: clk_div_multi

Overview:
- Multi-channel, runtime-programmable clock-enable/divided-clock generator; successor to the fixed-period single-output divider.
- Each channel has its own period and high time, loaded through a valid/ready config port and applied only at a period boundary, so outputs are glitch-free.
- Adds per-channel enable, start-of-period tick, and a common phase-resync input.
- Sits beside the system clock source and feeds peripheral strobes and slow domains.

Parameters:
- CHANNELS, 2, number of independent divider channels (>=1)
- CNT_W, 8, counter/period/duty width in bits
- DEF_PERIOD, 6, period in clk cycles loaded into every channel at reset (2..2^CNT_W-1)
- DEF_DUTY, 3, high cycles per period at reset (1..DEF_PERIOD-1)
- CH_W, max(1,$clog2(CHANNELS)), channel-select width

Ports:
- clk  input  1  system clock
- reset  input  1  synchronous, active-high reset
- en  input  CHANNELS  per-channel run enable, level
- sync  input  1  one-cycle pulse; restarts all running channels at count 0
- cfg_valid  input  1  config request
- cfg_ready  output  1  config can be accepted for cfg_chan (combinational)
- cfg_chan  input  CH_W  target channel
- cfg_period  input  CNT_W  new period
- cfg_duty  input  CNT_W  new high time
- cfg_err  output  1  registered one-cycle pulse: request rejected
- clk_div  output  CHANNELS  divided clock per channel, registered
- tick  output  CHANNELS  one-cycle pulse, registered, high when channel count is 0

Behaviour:
- One clock, clk. Reset is synchronous and active-high on reset. Priority per channel: reset > en=0 > start/sync/boundary > count.
- Reset: all cnt=0, running=0, clk_div=0, tick=0, cfg_err=0, pending=0. Active and shadow period/duty = DEF_PERIOD/DEF_DUTY.
- Per-channel state: cnt, running, active per/duty, shadow per/duty, pending.
- Stopped (running=0): cnt=0, clk_div=0, tick=0.
- Start: edge with en=1 and running=0 -> running<=1, cnt<=0, clk_div<=1, tick<=1. Output is high in the first cycle after en is sampled.
- Running, normal edge: cnt_next = (cnt==per-1) ? 0 : cnt+1. clk_div <= (cnt_next < duty). tick <= (cnt_next==0). Per running period: exactly duty high cycles, then per-duty low cycles; tick once per period.
- en=0 while running: next edge running<=0, cnt<=0, clk_div<=0, tick<=0. The stop is immediate; no period completion.
- Boundary: edge where running and cnt==per-1. If pending=1, active<=shadow and pending<=0. clk_div and tick for cnt_next=0 use the new duty.
- sync=1: every running channel takes cnt<=0, clk_div<=1, tick<=1 and applies pending as at a boundary. sync has no effect on stopped channels.
- Config handshake: cfg_ready = !pending[cfg_chan], or 1 when cfg_chan>=CHANNELS. A request transfers when cfg_valid && cfg_ready.
- Valid request (cfg_chan<CHANNELS, cfg_period>=2, 1<=cfg_duty<=cfg_period-1):
  - Running channel: shadow<=cfg, pending<=1.
  - Stopped channel: active<=cfg directly; pending stays 0.
- Invalid request: no state change; cfg_err<=1 for one cycle.
- Accept on the same edge as that channel's boundary or sync: the current edge uses the old values, the new config goes pending, and it applies at the next boundary.
- Accept to a stopped channel on the same edge as its start: the new active values take effect from the start cycle.
- Counter arithmetic is unsigned CNT_W. cnt never exceeds per-1.

Test Plan:
- Reset, then en[0]=1 held -> clk_div[0] = 1,1,1,0,0,0 repeating from the first post-start cycle; tick[0] every 6 cycles aligned with the first 1; clk_div[1]=0.
- Running ch0 at cnt=2: cfg ch0 period=4 duty=1 -> current period finishes as 6/3; then 1,0,0,0 repeating; cfg_ready for ch0 low from accept until the boundary edge.
- cfg ch1 period=1 duty=1, then ch1 period=5 duty=5, then cfg_chan=3 with CHANNELS=2 -> cfg_err pulse each time; ch1 config unchanged; no stall.
- ch0 period=6, ch1 period=4, both running at different phases; pulse sync -> both tick together next cycle and both clk_div=1; pending config applied at sync.
- Drop en[0] at cnt=1 -> clk_div[0]=0 next cycle, stays 0; re-raise en -> full high phase restarts at cnt 0.
- Assert reset mid-period with a pending config -> all outputs 0 next cycle; pending discarded; restart runs at 6/3.

Source files
------------

// File: rtl/clk_div_multi.sv
// rtl/clk_div_multi.sv - multi-channel programmable divided-clock / tick generator
// New period/duty values are staged in a shadow copy and applied only at a period boundary or sync.
module clk_div_multi #(
    parameter int CHANNELS   = 2,
    parameter int CNT_W      = 8,
    parameter int DEF_PERIOD = 6,
    parameter int DEF_DUTY   = 3,
    parameter int CH_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [CHANNELS-1:0] en,
    input  logic                sync,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_chan,
    input  logic [CNT_W-1:0]    cfg_period,
    input  logic [CNT_W-1:0]    cfg_duty,
    output logic                cfg_err,
    output logic [CHANNELS-1:0] clk_div,
    output logic [CHANNELS-1:0] tick
);

    logic [31:0]         chan_ext;
    logic                cfg_ok;
    logic                cfg_fire;
    logic [CHANNELS-1:0] pending_vec;

    assign chan_ext = 32'(cfg_chan);
    assign cfg_ok   = (chan_ext < 32'(CHANNELS)) && (cfg_period >= CNT_W'(2)) &&
                      (cfg_duty != '0) && (cfg_duty < cfg_period);
    assign cfg_fire = cfg_valid && cfg_ready;

    // Out-of-range channels are always ready so the bad request can be flagged.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < CHANNELS; i++) begin
            if (chan_ext == 32'(i)) begin
                cfg_ready = !pending_vec[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cfg_err <= 1'b0;
        end else begin
            cfg_err <= cfg_fire && !cfg_ok;
        end
    end

    for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] per;
        logic [CNT_W-1:0] duty;
        logic [CNT_W-1:0] sh_per;
        logic [CNT_W-1:0] sh_duty;
        logic [CNT_W-1:0] cnt_inc;
        logic             running;
        logic             pending;
        logic             div_q;
        logic             tick_q;
        logic             hit;
        logic             boundary;

        assign hit      = cfg_fire && cfg_ok && (chan_ext == 32'(g));
        assign boundary = (cnt == per - CNT_W'(1));
        assign cnt_inc  = cnt + CNT_W'(1);

        always_ff @(posedge clk) begin
            if (reset) begin
                cnt     <= '0;
                running <= 1'b0;
                pending <= 1'b0;
                div_q   <= 1'b0;
                tick_q  <= 1'b0;
                per     <= CNT_W'(DEF_PERIOD);
                duty    <= CNT_W'(DEF_DUTY);
                sh_per  <= CNT_W'(DEF_PERIOD);
                sh_duty <= CNT_W'(DEF_DUTY);
            end else if (!running) begin
                // Stopped channels take new config directly, effective from a same-edge start.
                if (hit) begin
                    per  <= cfg_period;
                    duty <= cfg_duty;
                end
                cnt <= '0;
                if (en[g]) begin
                    running <= 1'b1;
                    div_q   <= 1'b1;
                    tick_q  <= 1'b1;
                end else begin
                    div_q  <= 1'b0;
                    tick_q <= 1'b0;
                end
            end else begin
                if (hit) begin
                    sh_per  <= cfg_period;
                    sh_duty <= cfg_duty;
                    pending <= 1'b1;
                end
                if (!en[g]) begin
                    running <= 1'b0;
                    cnt     <= '0;
                    div_q   <= 1'b0;
                    tick_q  <= 1'b0;
                end else if (sync || boundary) begin
                    // duty is never 0, so the first cycle of a period is always high.
                    cnt    <= '0;
                    div_q  <= 1'b1;
                    tick_q <= 1'b1;
                    if (pending) begin
                        per     <= sh_per;
                        duty    <= sh_duty;
                        pending <= 1'b0;
                    end
                end else begin
                    cnt    <= cnt_inc;
                    div_q  <= (cnt_inc < duty);
                    tick_q <= 1'b0;
                end
            end
        end

        assign clk_div[g]     = div_q;
        assign tick[g]        = tick_q;
        assign pending_vec[g] = pending;
    end

endmodule

// File: tb/tb_clk_div_multi.sv
// tb/tb_clk_div_multi.sv - directed self-checking bench for clk_div_multi
// Three channels so that cfg_chan=3 is representable and out of range.
module tb_clk_div_multi;

    localparam int CHANNELS = 3;
    localparam int CNT_W    = 8;
    localparam int CH_W     = 2;

    logic                clk = 1'b0;
    logic                reset;
    logic [CHANNELS-1:0] en;
    logic                sync;
    logic                cfg_valid;
    logic                cfg_ready;
    logic [CH_W-1:0]     cfg_chan;
    logic [CNT_W-1:0]    cfg_period;
    logic [CNT_W-1:0]    cfg_duty;
    logic                cfg_err;
    logic [CHANNELS-1:0] clk_div;
    logic [CHANNELS-1:0] tick;

    int n_checks = 0;
    int n_pass   = 0;

    clk_div_multi #(
        .CHANNELS  (CHANNELS),
        .CNT_W     (CNT_W),
        .DEF_PERIOD(6),
        .DEF_DUTY  (3),
        .CH_W      (CH_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .en        (en),
        .sync      (sync),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_chan  (cfg_chan),
        .cfg_period(cfg_period),
        .cfg_duty  (cfg_duty),
        .cfg_err   (cfg_err),
        .clk_div   (clk_div),
        .tick      (tick)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int obs, input int exp);
        n_checks++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_set(input logic v, input int ch, input int p, input int d);
        cfg_valid  = v;
        cfg_chan   = CH_W'(ch);
        cfg_period = CNT_W'(p);
        cfg_duty   = CNT_W'(d);
    endtask

    initial begin
        reset = 1'b1;
        en    = '0;
        sync  = 1'b0;
        cfg_set(1'b0, 0, 0, 0);
        step;
        step;
        reset = 1'b0;
        #1;
        check("rst_div", int'(clk_div), 0);
        check("rst_tick", int'(tick), 0);
        check("rst_err", int'(cfg_err), 0);
        check("rst_ready", int'(cfg_ready), 1);

        // Default 6/3 on channel 0.
        en = 3'b001;
        step;
        for (int k = 0; k < 12; k++) begin
            check($sformatf("t1_div0_%0d", k), int'(clk_div[0]), (k % 6 < 3) ? 1 : 0);
            check($sformatf("t1_tick0_%0d", k), int'(tick[0]), (k % 6 == 0) ? 1 : 0);
            check($sformatf("t1_div1_%0d", k), int'(clk_div[1]), 0);
            step;
        end

        // Reconfigure ch0 to 4/1 at cnt=2; current period finishes as 6/3.
        step;
        step;
        cfg_set(1'b1, 0, 4, 1);
        #1;
        check("t2_ready_pre", int'(cfg_ready), 1);
        step;
        cfg_valid = 1'b0;
        for (int j = 3; j < 6; j++) begin
            check($sformatf("t2_old_div_%0d", j), int'(clk_div[0]), 0);
            check($sformatf("t2_ready_%0d", j), int'(cfg_ready), 0);
            step;
        end
        check("t2_ready_post", int'(cfg_ready), 1);
        for (int k = 0; k < 8; k++) begin
            check($sformatf("t2_div0_%0d", k), int'(clk_div[0]), (k % 4 == 0) ? 1 : 0);
            check($sformatf("t2_tick0_%0d", k), int'(tick[0]), (k % 4 == 0) ? 1 : 0);
            step;
        end

        // Rejected requests.
        cfg_set(1'b1, 1, 1, 1);
        #1;
        check("t3_ready_a", int'(cfg_ready), 1);
        step;
        check("t3_err_a", int'(cfg_err), 1);
        cfg_set(1'b1, 1, 5, 5);
        step;
        check("t3_err_b", int'(cfg_err), 1);
        cfg_set(1'b1, 3, 4, 2);
        #1;
        check("t3_ready_c", int'(cfg_ready), 1);
        step;
        check("t3_err_c", int'(cfg_err), 1);
        cfg_valid = 1'b0;
        step;
        check("t3_err_clr", int'(cfg_err), 0);
        en = 3'b011;
        step;
        for (int k = 0; k < 6; k++) begin
            check($sformatf("t3_div1_%0d", k), int'(clk_div[1]), (k < 3) ? 1 : 0);
            step;
        end

        // Pending configs on both channels, applied by sync.
        cfg_set(1'b1, 0, 6, 3);
        step;
        cfg_set(1'b1, 1, 4, 2);
        step;
        cfg_valid = 1'b0;
        #1;
        check("t4_ready1_pend", int'(cfg_ready), 0);
        sync = 1'b1;
        step;
        sync = 1'b0;
        check("t4_ready1_sync", int'(cfg_ready), 1);
        for (int k = 0; k < 12; k++) begin
            check($sformatf("t4_div0_%0d", k), int'(clk_div[0]), (k % 6 < 3) ? 1 : 0);
            check($sformatf("t4_tick0_%0d", k), int'(tick[0]), (k % 6 == 0) ? 1 : 0);
            check($sformatf("t4_div1_%0d", k), int'(clk_div[1]), (k % 4 < 2) ? 1 : 0);
            check($sformatf("t4_tick1_%0d", k), int'(tick[1]), (k % 4 == 0) ? 1 : 0);
            step;
        end

        // Stop ch0 at cnt=1, then restart it.
        step;
        en = 3'b010;
        step;
        for (int m = 0; m < 4; m++) begin
            check($sformatf("t5_stop_div0_%0d", m), int'(clk_div[0]), 0);
            check($sformatf("t5_stop_tick0_%0d", m), int'(tick[0]), 0);
            check($sformatf("t5_div1_%0d", m), int'(clk_div[1]), ((14 + m) % 4 < 2) ? 1 : 0);
            step;
        end
        en = 3'b011;
        step;
        for (int r = 0; r < 6; r++) begin
            check($sformatf("t5_re_div0_%0d", r), int'(clk_div[0]), (r < 3) ? 1 : 0);
            check($sformatf("t5_re_tick0_%0d", r), int'(tick[0]), (r == 0) ? 1 : 0);
            check($sformatf("t5_re_div1_%0d", r), int'(clk_div[1]), ((19 + r) % 4 < 2) ? 1 : 0);
            step;
        end

        // Reset with a pending config discards it.
        cfg_set(1'b1, 0, 4, 1);
        step;
        cfg_valid = 1'b0;
        #1;
        check("t6_ready_pend", int'(cfg_ready), 0);
        en    = 3'b001;
        reset = 1'b1;
        step;
        check("t6_rst_div", int'(clk_div), 0);
        check("t6_rst_tick", int'(tick), 0);
        check("t6_rst_ready", int'(cfg_ready), 1);
        check("t6_rst_err", int'(cfg_err), 0);
        reset = 1'b0;
        step;
        for (int k = 0; k < 12; k++) begin
            check($sformatf("t6_div0_%0d", k), int'(clk_div[0]), (k % 6 < 3) ? 1 : 0);
            check($sformatf("t6_tick0_%0d", k), int'(tick[0]), (k % 6 == 0) ? 1 : 0);
            check($sformatf("t6_div1_%0d", k), int'(clk_div[1]), 0);
            step;
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
